// File: rtl/host_cmd_ctrl.sv
// host_cmd_ctrl
//   Host-side command controller. Accepts one command at a time from a host
//   trigger, runs it over one or more cycles, then raises a one-cycle done
//   pulse. Supports ADD, repeated accumulate (ACC), 16x16 shift-add multiply
//   (MUL) and result clear (CLR). Sticky flags record overflow, commands that
//   arrived while busy, and aborted commands.
//
// Ports
//   ti_clk     : sole clock, all logic on the rising edge
//   reset      : synchronous, active-high
//   cmd_valid  : one-cycle command strobe (only honoured in IDLE)
//   cmd_op     : 00 ADD, 01 ACC, 10 MUL, 11 CLR
//   cmd_a      : operand A
//   cmd_b      : operand B
//   cmd_count  : ACC repeat count
//   abort      : one-cycle abort strobe (only honoured in RUN)
//   clr_flags  : one-cycle strobe clearing ovf / err_busy / aborted
//   busy       : high while a command is running
//   done       : one-cycle completion pulse
//   result     : result register
//   status     : {cmd_done_cnt[7:0], 2'b00, last_op, aborted, err_busy, ovf, busy}
//   led        : result[3:0], inverted when LED_INV = 1 (active-low LEDs)

module host_cmd_ctrl #(
    parameter bit LED_INV = 1'b1
) (
    input  logic        ti_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [7:0]  cmd_count,
    input  logic        abort,
    input  logic        clr_flags,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] status,
    output logic [3:0]  led
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ACC = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t      state_q,    state_d;
    logic [1:0]  op_q,       op_d;
    logic [31:0] opnd_a_q,   opnd_a_d;
    logic [15:0] opnd_b_q,   opnd_b_d;
    logic [31:0] prod_q,     prod_d;
    logic [7:0]  run_cnt_q,  run_cnt_d;
    logic [15:0] result_q,   result_d;
    logic        ovf_q,      ovf_d;
    logic        err_busy_q, err_busy_d;
    logic        aborted_q,  aborted_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [1:0]  last_op_q,  last_op_d;

    logic [15:0] sum_rhs;
    logic [16:0] sum;
    logic [31:0] prod_next;
    logic        last_run;
    logic        ovf_set;
    logic        err_set;
    logic        abt_set;
    logic        unused_cnt_hi;

    // Next-state and datapath. ADD adds B to A, ACC adds A to the running
    // result; both share one 17-bit adder whose carry feeds ovf. MUL keeps a
    // left-shifting multiplicand and right-shifting multiplier and only
    // publishes the product on its final RUN cycle, so an abort leaves the
    // previous result untouched. An abort on the final RUN cycle is ignored
    // so the command completes normally.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opnd_a_d   = opnd_a_q;
        opnd_b_d   = opnd_b_q;
        prod_d     = prod_q;
        run_cnt_d  = run_cnt_q;
        result_d   = result_q;
        done_cnt_d = done_cnt_q;
        last_op_d  = last_op_q;
        ovf_set    = 1'b0;
        err_set    = 1'b0;
        abt_set    = 1'b0;

        sum_rhs   = (op_q == OP_ADD) ? opnd_b_q : result_q;
        sum       = {1'b0, opnd_a_q[15:0]} + {1'b0, sum_rhs};
        prod_next = opnd_b_q[0] ? (prod_q + opnd_a_q) : prod_q;
        last_run  = (run_cnt_q == 8'd1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    last_op_d = cmd_op;
                    opnd_a_d  = {16'h0000, cmd_a};
                    opnd_b_d  = cmd_b;
                    prod_d    = 32'h0000_0000;
                    case (cmd_op)
                        OP_ADD: begin
                            run_cnt_d = 8'd1;
                            state_d   = ST_RUN;
                        end
                        OP_ACC: begin
                            run_cnt_d = cmd_count;
                            state_d   = (cmd_count != 8'd0) ? ST_RUN : ST_DONE;
                        end
                        OP_MUL: begin
                            run_cnt_d = 8'd16;
                            state_d   = ST_RUN;
                        end
                        default: begin
                            result_d = 16'h0000;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                err_set = cmd_valid;
                if (abort && !last_run) begin
                    abt_set = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    run_cnt_d = run_cnt_q - 8'd1;
                    case (op_q)
                        OP_ADD, OP_ACC: begin
                            result_d = sum[15:0];
                            ovf_set  = sum[16];
                        end
                        OP_MUL: begin
                            prod_d   = prod_next;
                            opnd_a_d = opnd_a_q << 1;
                            opnd_b_d = opnd_b_q >> 1;
                            if (last_run) begin
                                result_d = prod_next[15:0];
                                ovf_set  = |prod_next[31:16];
                            end
                        end
                        default: ;
                    endcase
                    if (last_run) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                err_set    = cmd_valid;
                done_cnt_d = done_cnt_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a clear strobe loses against a set event on the same edge.
    always_comb begin
        ovf_d      = (ovf_q      & ~clr_flags) | ovf_set;
        err_busy_d = (err_busy_q & ~clr_flags) | err_set;
        aborted_d  = (aborted_q  & ~clr_flags) | abt_set;
    end

    // State register; reset overrides every other input.
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            opnd_a_q   <= 32'h0000_0000;
            opnd_b_q   <= 16'h0000;
            prod_q     <= 32'h0000_0000;
            run_cnt_q  <= 8'd0;
            result_q   <= 16'h0000;
            ovf_q      <= 1'b0;
            err_busy_q <= 1'b0;
            aborted_q  <= 1'b0;
            done_cnt_q <= 16'h0000;
            last_op_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_a_q   <= opnd_a_d;
            opnd_b_q   <= opnd_b_d;
            prod_q     <= prod_d;
            run_cnt_q  <= run_cnt_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            err_busy_q <= err_busy_d;
            aborted_q  <= aborted_d;
            done_cnt_q <= done_cnt_d;
            last_op_q  <= last_op_d;
        end
    end

    // The full 16-bit counter wraps naturally; only its low byte is visible.
    assign unused_cnt_hi = ^done_cnt_q[15:8];

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign status = {done_cnt_q[7:0], 2'b00, last_op_q, aborted_q, err_busy_q, ovf_q, busy};
    assign led    = LED_INV ? ~result_q[3:0] : result_q[3:0];

endmodule

// File: doc/host_cmd_ctrl.md
HOST_CMD_CTRL -- requirements
Module: host_cmd_ctrl

Interface
REQ-001 Parameter LED_INV, default 1: 1 = LEDs are active-low, so led is the inverse of result[3:0]; 0 = led equals result[3:0].
REQ-002 ti_clk  in  1  sole clock (host interface clock); all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  one-cycle command strobe (from TriggerIn).
REQ-005 cmd_op  in  2  opcode: 00 ADD, 01 ACC, 10 MUL, 11 CLR.
REQ-006 cmd_a  in  16  operand A (WireIn).
REQ-007 cmd_b  in  16  operand B (WireIn).
REQ-008 cmd_count  in  8  ACC repeat count (WireIn).
REQ-009 abort  in  1  one-cycle abort strobe.
REQ-010 clr_flags  in  1  one-cycle strobe that clears the sticky flags.
REQ-011 busy  out  1  high while in RUN.
REQ-012 done  out  1  one-cycle completion pulse (TriggerOut).
REQ-013 result  out  16  result register (WireOut).
REQ-014 status  out  16  status word (WireOut).
REQ-015 led  out  4  LED drive.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 The FSM SHALL accept a command only when cmd_valid=1 in IDLE; operands and opcode latched on that edge; cmd_a/cmd_b/cmd_count/cmd_op ignored afterward until next acceptance.
REQ-018 On acceptance, ADD and MUL SHALL go to RUN; ACC SHALL go to RUN if cmd_count≠0, else to DONE; CLR SHALL go to DONE with result=0.
REQ-019 ADD SHALL spend 1 RUN cycle computing result=(A+B) mod 2^16; ovf is set if there is a carry out.
REQ-020 ACC SHALL spend cmd_count RUN cycles; each cycle it computes result=(result+A) mod 2^16; ovf is set on any carry; the prior result is the starting value.
REQ-021 MUL SHALL spend exactly 16 RUN cycles of shift-add over a 32-bit product; on exit, result=product[15:0]; ovf is set if product[31:16]≠0.
REQ-022 Latency from acceptance edge (cycle 0): ADD done at cycle 2, ACC N done at cycle N+1 (N=0: cycle 1), MUL done at cycle 17, CLR done at cycle 1.
REQ-023 RUN SHALL exit to DONE; DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-024 result SHALL be stable and final in the done cycle; result is not updated outside RUN/CLR, except MUL, which updates only on its last RUN cycle.
REQ-025 cmd_valid in RUN or DONE SHALL be dropped (no queuing) and SHALL set sticky err_busy.
REQ-026 abort in RUN SHALL force DONE on the next edge, set sticky aborted, and leave result at its partial value; abort in IDLE/DONE SHALL be ignored.
REQ-027 If abort and the final RUN cycle coincide, the command SHALL complete normally and aborted SHALL NOT be set.
REQ-028 clr_flags SHALL clear ovf, err_busy and aborted; if it coincides with a setting event, set wins.
REQ-029 A 16-bit completed-command counter SHALL increment on every done pulse, including aborted ones, and wrap 0xFFFF→0x0000.
REQ-030 status SHALL be {cmd_done_cnt[7:0], 2'b00, last_op[1:0], aborted, err_busy, ovf, busy}.
REQ-031 led SHALL be driven combinationally from result[3:0] per LED_INV.

Reset
REQ-032 reset SHALL force IDLE, result=0, all flags=0, counter=0, last_op=00, busy=0 and done=0 on the same edge; led=4'hF when LED_INV=1.
REQ-033 reset mid-RUN SHALL abandon the command without a done pulse; reset has priority over all inputs.

Verification
REQ-034 ADD: A=0x0003, B=0x0004 -> done at cycle 2, result=0x0007, ovf=0, led=4'b1000 (LED_INV=1).
REQ-035 ADD: A=0xFFFF, B=0x0002 -> result=0x0001, status[1]=1; then clr_flags -> status[1]=0.
REQ-036 CLR, then ACC with A=0x0010, count=5 -> done at cycle 6, result=0x0050; ACC count=0 -> done at cycle 1, result unchanged.
REQ-037 MUL: A=0x0100, B=0x0100 -> done at cycle 17, result=0x0000, ovf=1; A=0x00FF, B=0x0003 -> result=0x02FD, ovf=0.
REQ-038 MUL with abort at cycle 5 -> done at cycle 6, status[3]=1; cmd_valid during RUN -> status[2]=1 and the command is dropped.
REQ-039 reset at MUL cycle 8 -> no done pulse, all outputs at reset values; a new ADD is accepted on the next cycle.
